// File: rtl/bypass_scoreboard.sv
// Decode-stage operand bypass with a per-register latency scoreboard.
// Each read port is resolved against the exec/mem/wb buses, and decode stalls while a multi-cycle producer is still pending.
module bypass_scoreboard #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int READ_PORTS     = 2,
    parameter int MAX_LAT        = 4,
    localparam int PA            = REG_ADDR_WIDTH + 1,
    localparam int LAT_W         = $clog2(MAX_LAT + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             issue_valid,
    input  logic                             issue_wb_reg,
    input  logic [PA-1:0]                    issue_addr,
    input  logic [LAT_W-1:0]                 issue_latency,
    input  logic [READ_PORTS-1:0]            dec_rd_enable,
    input  logic [READ_PORTS*PA-1:0]         dec_rd_addr,
    input  logic [READ_PORTS*DATA_WIDTH-1:0] dec_rd_data,
    input  logic                             exec_wb_reg,
    input  logic [PA-1:0]                    exec_write_addr,
    input  logic [DATA_WIDTH-1:0]            exec_write,
    input  logic                             mem_wb_reg,
    input  logic [PA-1:0]                    mem_write_addr,
    input  logic [DATA_WIDTH-1:0]            mem_write,
    input  logic                             wb_wb_reg,
    input  logic [PA-1:0]                    wb_write_addr,
    input  logic [DATA_WIDTH-1:0]            wb_write,
    output logic [READ_PORTS*DATA_WIDTH-1:0] dec_rd_override,
    output logic                             dec_stall,
    output logic [31:0]                      stall_count
);

    localparam int              NREG      = 1 << PA;
    localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
    localparam logic [31:0]      CNT_MAX   = 32'hFFFF_FFFF;

    logic [LAT_W-1:0]      pend_r     [NREG];
    logic [LAT_W-1:0]      pend_nxt_s [NREG];
    logic                  issue_hit_s;
    logic [READ_PORTS-1:0] port_stall_s;
    logic                  stall_s;
    logic [31:0]           stall_count_r;

    // Producer latencies beyond the tracked range saturate at MAX_LAT.
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        if (lat > MAX_LAT_V) begin
            return MAX_LAT_V;
        end else begin
            return lat;
        end
    endfunction

    // Qualified scoreboard write: register 0 is never a real destination.
    always_comb begin
        issue_hit_s = issue_valid && issue_wb_reg && (issue_addr != '0);
    end

    // Next scoreboard state: flush clears, issue overwrites, everything else counts down.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_nxt_s[r] = '0;
            if (r == 0) begin
                pend_nxt_s[r] = '0;
            end else if (flush) begin
                pend_nxt_s[r] = '0;
            end else if (issue_hit_s && (issue_addr == PA'(r))) begin
                pend_nxt_s[r] = clamp_lat(issue_latency);
            end else if (pend_r[r] != '0) begin
                pend_nxt_s[r] = pend_r[r] - LAT_ONE;
            end else begin
                pend_nxt_s[r] = '0;
            end
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (rst) begin
                pend_r[r] <= '0;
            end else begin
                pend_r[r] <= pend_nxt_s[r];
            end
        end
    end

    generate
        for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
            logic [PA-1:0]         addr_s;
            logic [DATA_WIDTH-1:0] fwd_s;
            logic                  live_s;

            assign addr_s = dec_rd_addr[i*PA +: PA];
            assign live_s = dec_rd_enable[i] && (addr_s != '0);

            // Youngest producer wins: exec, then mem, then wb, else the register file.
            always_comb begin
                fwd_s = dec_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                if (live_s && exec_wb_reg && (exec_write_addr == addr_s)) begin
                    fwd_s = exec_write;
                end else if (live_s && mem_wb_reg && (mem_write_addr == addr_s)) begin
                    fwd_s = mem_write;
                end else if (live_s && wb_wb_reg && (wb_write_addr == addr_s)) begin
                    fwd_s = wb_write;
                end else begin
                    fwd_s = dec_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // A port stalls while its source still has a producer in flight.
            always_comb begin
                if (live_s && (pend_r[addr_s] != '0)) begin
                    port_stall_s[i] = 1'b1;
                end else begin
                    port_stall_s[i] = 1'b0;
                end
            end

            assign dec_rd_override[i*DATA_WIDTH +: DATA_WIDTH] = fwd_s;
        end
    endgenerate

    // Any port waiting on a producer holds decode.
    always_comb begin
        stall_s = |port_stall_s;
    end

    // Saturating stalled-cycle counter, kept across flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 32'd0;
        end else if (stall_s && (stall_count_r != CNT_MAX)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign dec_stall   = stall_s;
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: a 2-port and a 3-port instance share all stimulus.
module tb_bypass_scoreboard;

    localparam int DW   = 32;
    localparam int PA   = 6;
    localparam int LATW = 3;

    logic             clk = 1'b0;
    logic             rst, flush, issue_valid, issue_wb_reg;
    logic [PA-1:0]    issue_addr;
    logic [LATW-1:0]  issue_latency;
    logic [2:0]       rd_en;
    logic [3*PA-1:0]  rd_addr;
    logic [3*DW-1:0]  rd_data;
    logic             exec_v, mem_v, wb_v;
    logic [PA-1:0]    exec_a, mem_a, wb_a;
    logic [DW-1:0]    exec_d, mem_d, wb_d;
    logic [2*DW-1:0]  ovr2;
    logic [3*DW-1:0]  ovr3;
    logic             stall2, stall3;
    logic [31:0]      count2, count3;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bypass_scoreboard #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(5), .READ_PORTS(2), .MAX_LAT(4)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_wb_reg(issue_wb_reg),
        .issue_addr(issue_addr), .issue_latency(issue_latency),
        .dec_rd_enable(rd_en[1:0]), .dec_rd_addr(rd_addr[2*PA-1:0]), .dec_rd_data(rd_data[2*DW-1:0]),
        .exec_wb_reg(exec_v), .exec_write_addr(exec_a), .exec_write(exec_d),
        .mem_wb_reg(mem_v), .mem_write_addr(mem_a), .mem_write(mem_d),
        .wb_wb_reg(wb_v), .wb_write_addr(wb_a), .wb_write(wb_d),
        .dec_rd_override(ovr2), .dec_stall(stall2), .stall_count(count2));

    bypass_scoreboard #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(5), .READ_PORTS(3), .MAX_LAT(4)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_wb_reg(issue_wb_reg),
        .issue_addr(issue_addr), .issue_latency(issue_latency),
        .dec_rd_enable(rd_en), .dec_rd_addr(rd_addr), .dec_rd_data(rd_data),
        .exec_wb_reg(exec_v), .exec_write_addr(exec_a), .exec_write(exec_d),
        .mem_wb_reg(mem_v), .mem_write_addr(mem_a), .mem_write(mem_d),
        .wb_wb_reg(wb_v), .wb_write_addr(wb_a), .wb_write(wb_d),
        .dec_rd_override(ovr3), .dec_stall(stall3), .stall_count(count3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h with no expected value", obs);
        end else begin
            e = q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic set_port(input int p, input logic en, input logic [PA-1:0] a, input logic [DW-1:0] d);
        rd_en[p]            = en;
        rd_addr[p*PA +: PA] = a;
        rd_data[p*DW +: DW] = d;
    endtask

    task automatic issue(input logic v, input logic [PA-1:0] a, input logic [LATW-1:0] lat);
        issue_valid   = v;
        issue_wb_reg  = v;
        issue_addr    = a;
        issue_latency = lat;
    endtask

    function automatic logic [31:0] o2(input int p);
        return ovr2[p*DW +: DW];
    endfunction

    function automatic logic [31:0] o3(input int p);
        return ovr3[p*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0;
        issue(1'b0, 6'd0, 3'd0);
        rd_en = 3'b000; rd_addr = '0; rd_data = '0;
        exec_v = 1'b0; mem_v = 1'b0; wb_v = 1'b0;
        exec_a = 6'd0; mem_a = 6'd0; wb_a = 6'd0;
        exec_d = 32'd0; mem_d = 32'd0; wb_d = 32'd0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        set_port(0, 1'b1, 6'd3, 32'h1111); set_port(1, 1'b1, 6'd3, 32'h2222);
        expect_val("rst_stall", 32'd0); expect_val("rst_count", 32'd0); expect_val("rst_count3", 32'd0);
        expect_val("rst_ovr0", 32'h1111); expect_val("rst_ovr1", 32'h2222);
        settle();
        check({31'd0, stall2}); check(count2); check(count3); check(o2(0)); check(o2(1));

        // forwarding priority
        set_port(0, 1'b1, 6'd5, 32'h0); set_port(1, 1'b1, 6'd6, 32'h6666);
        exec_v = 1'b1; exec_a = 6'd5; exec_d = 32'd1;
        mem_v  = 1'b1; mem_a  = 6'd5; mem_d  = 32'd2;
        wb_v   = 1'b1; wb_a   = 6'd5; wb_d   = 32'd3;
        expect_val("fwd_exec", 32'd1); expect_val("fwd_p1_nomatch", 32'h6666);
        settle(); check(o2(0)); check(o2(1));
        exec_v = 1'b0;
        expect_val("fwd_mem", 32'd2); settle(); check(o2(0));
        mem_v = 1'b0;
        expect_val("fwd_wb", 32'd3); settle(); check(o2(0));
        wb_v = 1'b0;
        expect_val("fwd_none", 32'd0); settle(); check(o2(0));
        exec_v = 1'b1; exec_a = 6'd6; exec_d = 32'hE6;
        expect_val("fwd_p1_exec", 32'hE6); settle(); check(o2(1));
        exec_v = 1'b0;

        // register zero
        set_port(0, 1'b1, 6'd0, 32'd0); set_port(1, 1'b0, 6'd0, 32'd0);
        exec_v = 1'b1; exec_a = 6'd0; exec_d = 32'hDEAD;
        expect_val("zero_ovr", 32'd0); expect_val("zero_stall", 32'd0);
        settle(); check(o2(0)); check({31'd0, stall2});
        exec_v = 1'b0;
        issue(1'b1, 6'd0, 3'd3);
        tick();
        issue(1'b0, 6'd0, 3'd0);
        expect_val("zero_issue_stall", 32'd0); settle(); check({31'd0, stall2});

        // load-use, latency 2
        set_port(0, 1'b0, 6'd0, 32'd0);
        issue(1'b1, 6'd7, 3'd2);
        tick();
        issue(1'b0, 6'd0, 3'd0);
        set_port(0, 1'b1, 6'd7, 32'h70);
        expect_val("lu_stall_c1", 32'd1); settle(); check({31'd0, stall2});
        tick();
        expect_val("lu_stall_c2", 32'd1); settle(); check({31'd0, stall2});
        tick();
        exec_v = 1'b1; exec_a = 6'd7; exec_d = 32'h77;
        expect_val("lu_stall_c3", 32'd0); expect_val("lu_ovr", 32'h77); expect_val("lu_count", 32'd2);
        settle(); check({31'd0, stall2}); check(o2(0)); check(count2);
        exec_v = 1'b0;

        // re-issue over a pending entry, then latency clamp
        set_port(0, 1'b0, 6'd0, 32'd0);
        issue(1'b1, 6'd9, 3'd1);
        tick();
        issue(1'b1, 6'd9, 3'd3);
        set_port(0, 1'b1, 6'd9, 32'h90);
        expect_val("ri_stall_old", 32'd1); settle(); check({31'd0, stall2});
        tick();
        issue(1'b0, 6'd0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            expect_val("ri_stall_new", 32'd1); settle(); check({31'd0, stall2});
            tick();
        end
        expect_val("ri_clear", 32'd0); expect_val("ri_count", 32'd6);
        settle(); check({31'd0, stall2}); check(count2);
        set_port(0, 1'b0, 6'd0, 32'd0);
        issue(1'b1, 6'd9, 3'd7);
        tick();
        issue(1'b0, 6'd0, 3'd0);
        set_port(0, 1'b1, 6'd9, 32'h90);
        for (int k = 0; k < 4; k++) begin
            expect_val("clamp_stall", 32'd1); settle(); check({31'd0, stall2});
            tick();
        end
        expect_val("clamp_clear", 32'd0); expect_val("clamp_count", 32'd10);
        settle(); check({31'd0, stall2}); check(count2);

        // flush discards pending and same-cycle issue
        set_port(0, 1'b0, 6'd0, 32'd0);
        issue(1'b1, 6'd4, 3'd3);
        tick();
        set_port(0, 1'b1, 6'd4, 32'h40);
        flush = 1'b1;
        issue(1'b1, 6'd6, 3'd2);
        expect_val("fl_pre_stall", 32'd1); settle(); check({31'd0, stall2});
        tick();
        flush = 1'b0;
        issue(1'b0, 6'd0, 3'd0);
        set_port(1, 1'b1, 6'd6, 32'h60);
        expect_val("fl_no_stall", 32'd0); expect_val("fl_count_kept", 32'd11);
        settle(); check({31'd0, stall2}); check(count2);

        // reset mid-operation
        set_port(0, 1'b0, 6'd0, 32'd0); set_port(1, 1'b0, 6'd0, 32'd0);
        issue(1'b1, 6'd10, 3'd4);
        tick();
        issue(1'b0, 6'd0, 3'd0);
        set_port(0, 1'b1, 6'd10, 32'hA0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val("rs_stall", 32'd0); expect_val("rs_count", 32'd0);
        settle(); check({31'd0, stall2}); check(count2);

        // three read ports
        set_port(0, 1'b0, 6'd0, 32'd0);
        issue(1'b1, 6'd12, 3'd3);
        tick();
        issue(1'b0, 6'd0, 3'd0);
        set_port(0, 1'b1, 6'd1, 32'h10); set_port(1, 1'b1, 6'd2, 32'h20); set_port(2, 1'b1, 6'd12, 32'h0C0C);
        mem_v = 1'b1; mem_a = 6'd12; mem_d = 32'hABCD;
        expect_val("mp_stall3", 32'd1); expect_val("mp_stall2", 32'd0); expect_val("mp_ovr2_mem", 32'hABCD);
        settle(); check({31'd0, stall3}); check({31'd0, stall2}); check(o3(2));
        set_port(2, 1'b0, 6'd12, 32'h0C0C);
        expect_val("mp_stall3_dis", 32'd0); expect_val("mp_ovr2_dis", 32'h0C0C);
        settle(); check({31'd0, stall3}); check(o3(2));
        mem_v = 1'b0;

        if (q.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
